// File: rtl/lcd_timing_gen.sv
// Raster timing generator for the 1024x600 LVDS panel (runs on tx_sclk).
// Produces the h/v region flags, sync pulses, data enable and pixel
// coordinates. It also issues a per-line prefetch request LINE_REQ_LEAD
// cycles before each active line. The generator starts and stops only on
// frame boundaries.
//
// Ports:
//   clk          pixel clock
//   rst          synchronous active-high reset
//   en           run enable (level)
//   h_valid      horizontal active region
//   v_valid      vertical active region
//   de           h_valid & v_valid
//   hsync        horizontal sync region
//   vsync        vertical sync lines
//   x, y         horizontal / vertical counters
//   frame_start  one-cycle pulse on the first pixel of each frame
//   line_req     one-cycle line prefetch pulse
//   line_req_y   active line index being requested (valid with line_req)
//   running      high while the raster is being scanned
module lcd_timing_gen #(
    parameter int unsigned H_ACTIVE      = 1024,
    parameter int unsigned H_FP          = 24,
    parameter int unsigned H_SYNC        = 136,
    parameter int unsigned H_BP          = 160,
    parameter int unsigned V_ACTIVE      = 600,
    parameter int unsigned V_FP          = 12,
    parameter int unsigned V_SYNC        = 3,
    parameter int unsigned V_BP          = 20,
    parameter int unsigned LINE_REQ_LEAD = 256,
    parameter int unsigned X_W           = 11,
    parameter int unsigned Y_W           = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    output logic           h_valid,
    output logic           v_valid,
    output logic           de,
    output logic           hsync,
    output logic           vsync,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           frame_start,
    output logic           line_req,
    output logic [Y_W-1:0] line_req_y,
    output logic           running
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = VS_BEG + V_SYNC;
    localparam int unsigned REQ_X   = H_TOTAL - LINE_REQ_LEAD;
    localparam int unsigned PC_W    = (LINE_REQ_LEAD > 1) ? $clog2(LINE_REQ_LEAD) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRIME     = 2'd1,
        RUN       = 2'd2,
        STOP_PEND = 2'd3
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pcnt;

    // Counter advance and region decode of the *next* counter values, so the
    // registered outputs line up with the counters they are stored beside.
    logic           end_line;
    logic           end_frame;
    logic [X_W-1:0] nhc;
    logic [Y_W-1:0] nvc;
    logic [Y_W-1:0] nv;
    logic           d_hv;
    logic           d_vv;
    logic           d_hs;
    logic           d_vs;
    logic           d_fs;
    logic           req_hit;

    always_comb begin
        end_line  = (x == X_W'(H_TOTAL - 1));
        end_frame = end_line && (y == Y_W'(V_TOTAL - 1));
        nhc       = end_line ? '0 : x + X_W'(1);
        nvc       = end_frame ? '0 : (end_line ? y + Y_W'(1) : y);
        nv        = (nvc == Y_W'(V_TOTAL - 1)) ? '0 : nvc + Y_W'(1);
        d_hv      = (nhc < X_W'(H_ACTIVE));
        d_vv      = (nvc < Y_W'(V_ACTIVE));
        d_hs      = (nhc >= X_W'(HS_BEG)) && (nhc < X_W'(HS_END));
        d_vs      = (nvc >= Y_W'(VS_BEG)) && (nvc < Y_W'(VS_END));
        d_fs      = (nhc == '0) && (nvc == '0);
        req_hit   = (nhc == X_W'(REQ_X)) && (nv < Y_W'(V_ACTIVE));
    end

    // Sequencer: outputs default to 0 each cycle and are overridden per state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pcnt        <= '0;
            x           <= '0;
            y           <= '0;
            h_valid     <= 1'b0;
            v_valid     <= 1'b0;
            de          <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            frame_start <= 1'b0;
            line_req    <= 1'b0;
            line_req_y  <= '0;
            running     <= 1'b0;
        end else begin
            x           <= '0;
            y           <= '0;
            h_valid     <= 1'b0;
            v_valid     <= 1'b0;
            de          <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            frame_start <= 1'b0;
            line_req    <= 1'b0;
            line_req_y  <= '0;
            running     <= 1'b0;

            case (state)
                IDLE: begin
                    pcnt <= '0;
                    if (en) begin
                        // Prefetch of line 0 goes out on the first PRIME cycle.
                        state      <= PRIME;
                        line_req   <= 1'b1;
                        line_req_y <= '0;
                    end
                end

                PRIME: begin
                    if (pcnt == PC_W'(LINE_REQ_LEAD - 1)) begin
                        pcnt <= '0;
                        if (en) begin
                            // First pixel of the first frame: hc = vc = 0.
                            state       <= RUN;
                            h_valid     <= 1'b1;
                            v_valid     <= 1'b1;
                            de          <= 1'b1;
                            frame_start <= 1'b1;
                            running     <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        pcnt <= pcnt + PC_W'(1);
                    end
                end

                RUN, STOP_PEND: begin
                    if ((state == STOP_PEND) && !en && end_frame) begin
                        state <= IDLE;
                    end else begin
                        state       <= en ? RUN : STOP_PEND;
                        x           <= nhc;
                        y           <= nvc;
                        h_valid     <= d_hv;
                        v_valid     <= d_vv;
                        de          <= d_hv && d_vv;
                        hsync       <= d_hs;
                        vsync       <= d_vs;
                        frame_start <= d_fs;
                        running     <= 1'b1;
                        // Line-0 prefetch belongs to the next frame; skip it
                        // when that frame will not be started.
                        line_req    <= req_hit && ((nv != '0) || en);
                        line_req_y  <= req_hit ? nv : '0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
